// File: rtl/seg7_scan_pkg.sv
// Shared definitions for the seg7_scan display driver.
//   NDIG          number of digits driven
//   SEG_OFF       all segments dark (active-low {g,f,e,d,c,b,a})
//   AN_OFF        all anodes disabled (active-low)
//   SEG_0..SEG_F  active-low hex glyph patterns
package seg7_scan_pkg;

  localparam int unsigned NDIG = 4;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/seg7_scan_hex2seg.sv
// Pure combinational hex-to-7-segment decoder (common anode, active-low).
//   value  in  4  hex nibble
//   seg    out 7  {g,f,e,d,c,b,a}, 0 = segment lit
module seg7_scan_hex2seg
  import seg7_scan_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    unique case (value)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Each digit slot is CLK_DIV cycles long; the first BLANK_CYC cycles of every slot keep all
// anodes dark so digit changes never ghost. Inputs are snapshotted once per frame (and on the
// first edge after reset) so a digit set cannot tear mid-frame.
// Optional feature macro: SEG7_LZ_BLANK_EN -- leading-zero suppression of d3..d1 at snapshot.
// Ports:
//   clk         in   1  system clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   d0..d3      in   4  hex digit values, d0 = rightmost
//   dp_in       in   4  decimal point per digit, 1 = lit
//   blank       in   4  per-digit force-dark, 1 = digit off
//   an          out  4  anode enables, active-low, an[i] drives digit i
//   seg         out  7  {g,f,e,d,c,b,a}, active-low
//   dp          out  1  decimal point, active-low
//   frame_tick  out  1  one-cycle pulse when a new snapshot is taken
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned DIV_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] dp_in,
  input  logic [3:0] blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  logic [DIV_W-1:0]         cnt_q, cnt_d;
  logic [1:0]               idx_q, idx_d;
  logic                     first_q;
  logic [NDIG-1:0][3:0]     sd_q;
  logic [NDIG-1:0]          sdp_q;
  logic [NDIG-1:0]          sblank_q;
  logic [NDIG-1:0]          blank_eff;

  logic                     wrap;
  logic                     snap_en;
  logic                     lit;
  logic [6:0]               cur_seg;
  logic [3:0]               an_d;
  logic [6:0]               seg_d;
  logic                     dp_d;

  // Prescaler and digit index.
  always_comb begin
    wrap    = (cnt_q == DIV_W'(CLK_DIV - 1));
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    idx_d   = wrap ? idx_q + 2'd1 : idx_q;
    // first_q forces a snapshot on the first edge out of reset.
    snap_en = first_q | (wrap & (idx_q == 2'd3));
  end

`ifdef SEG7_LZ_BLANK_EN
  logic shown3, shown2;
  // A higher digit stops suppression only if it would actually be visible.
  always_comb begin
    shown3    = (d3 != 4'h0) && !blank[3];
    shown2    = (d2 != 4'h0) && !blank[2];
    blank_eff = blank;
    blank_eff[3] = blank[3] | (d3 == 4'h0);
    blank_eff[2] = blank[2] | ((d2 == 4'h0) && !shown3);
    blank_eff[1] = blank[1] | ((d1 == 4'h0) && !shown3 && !shown2);
  end
`else
  always_comb begin
    blank_eff = blank;
  end
`endif

  seg7_scan_hex2seg u_hex2seg (
    .value (sd_q[idx_q]),
    .seg   (cur_seg)
  );

  // Output decode; registered below, so outputs lag cnt/idx by one cycle.
  always_comb begin
    lit   = (cnt_q >= DIV_W'(BLANK_CYC)) && !sblank_q[idx_q];
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (lit) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = cur_seg;
      dp_d  = ~sdp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      first_q    <= 1'b1;
      sd_q       <= '0;
      sdp_q      <= '0;
      sblank_q   <= '0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      first_q    <= 1'b0;
      frame_tick <= snap_en;
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      if (snap_en) begin
        sd_q     <= {d3, d2, d1, d0};
        sdp_q    <= dp_in;
        sblank_q <= blank_eff;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan (CLK_DIV=4, BLANK_CYC=1). Stimulus pushes the expected lit
// slots of each frame when its snapshot is taken; a monitor pops one entry each time an anode
// turns on and also watches that at most one anode is low and lit digits never abut.
module tb_seg7_scan;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] dv = 16'h0;  // {d3,d2,d1,d0}
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  logic [3:0] prev_an = 4'hF;

  always #5 clk = ~clk;

  seg7_scan #(
    .CLK_DIV   (4),
    .BLANK_CYC (1),
    .DIV_W     (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d0         (dv[3:0]),
    .d1         (dv[7:4]),
    .d2         (dv[11:8]),
    .d3         (dv[15:12]),
    .dp_in      (dp_in),
    .blank      (blank),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic push_frame(input logic [15:0] dd, input logic [3:0] dpi, input logic [3:0] blk);
    logic [3:0] eb;
    exp_t       e;
    eb = blk;
`ifdef SEG7_LZ_BLANK_EN
    begin
      bit leading;
      leading = 1'b1;
      for (int i = 3; i >= 1; i--) begin
        if (leading && dd[i*4 +: 4] == 4'h0) eb[i] = 1'b1;
        else if (dd[i*4 +: 4] != 4'h0 && !blk[i]) leading = 1'b0;
      end
    end
`endif
    for (int i = 0; i < 4; i++) begin
      if (!eb[i]) begin
        e.an  = ~(4'b0001 << i);
        e.seg = glyph(dd[i*4 +: 4]);
        e.dp  = ~dpi[i];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_tick(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: frame_tick not seen within 40 cycles", name);
    end
  endtask

  // Apply inputs now; they take effect at the next snapshot, whose lit slots are then queued.
  task automatic apply(input logic [15:0] dd, input logic [3:0] dpi, input logic [3:0] blk,
                       input string name);
    dv    = dd;
    dp_in = dpi;
    blank = blk;
    wait_tick(name);
    push_frame(dd, dpi, blk);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    n_cmp++;
    if (!(an inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7})) begin
      n_fail++;
      $display("FAIL an_onehot: an=%h, required F/E/D/B/7", an);
    end
    if (prev_an != 4'hF && an != 4'hF && an != prev_an) begin
      n_cmp++;
      n_fail++;
      $display("FAIL an_gap: an went %h -> %h without all-high", prev_an, an);
    end
    if (prev_an == 4'hF && an != 4'hF) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_lit: an=%h seg=%h dp=%b, no digit expected", an, seg, dp);
      end else begin
        e = exp_q.pop_front();
        if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
          n_fail++;
          $display("FAIL slot: got an=%h seg=%h dp=%b, required an=%h seg=%h dp=%b",
                   an, seg, dp, e.an, e.seg, e.dp);
        end
      end
    end
    prev_an = an;
  end

  task automatic check_dark(input string name);
    n_cmp++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got an=%h seg=%h dp=%b tick=%b, required F/7F/1/0",
               name, an, seg, dp, frame_tick);
    end
  endtask

  task automatic release_and_snap(input string name);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (frame_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: frame_tick=%b on first edge after reset, required 1", name, frame_tick);
    end
    push_frame(dv, dp_in, blank);
  endtask

  initial begin
    bit found;
    // 1: reset held 3 cycles with digits 1,2,3,4 presented.
    dv = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_dark("reset_out");
    end
    release_and_snap("tick_first_edge");

    // 3: mid-frame (idx1) change of d0 and d2 must not affect the frame being shown.
    repeat (5) @(negedge clk);
    apply(16'h1538, 4'h0, 4'h0, "frame_d0_change");

    // 4: digit 2 forced dark, dp on digit 0 only.
    apply(16'h1538, 4'b0001, 4'b0100, "frame_blank_dp");

    // 5: zero-heavy patterns (suppressed only with SEG7_LZ_BLANK_EN).
    apply(16'h0070, 4'h0, 4'h0, "frame_lz_0070");
    apply(16'h0000, 4'h0, 4'h0, "frame_lz_0000");

    // 6: reset in the middle of a lit idx2 slot.
    apply(16'h9ABC, 4'b1010, 4'h0, "frame_pre_reset");
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an == 4'hB) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL idx2_lit: an=%h, required B within 40 cycles", an);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_dark("async_reset");
    exp_q.delete();
    dv    = 16'hEF06;
    dp_in = 4'b0100;
    blank = 4'b0000;
    @(negedge clk);
    check_dark("reset_hold");
    @(negedge clk);
    release_and_snap("tick_after_reset");

    // Let the post-reset frame finish; every queued slot must have been shown.
    wait_tick("frame_after_reset");
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d slots not shown, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
